instr_decode_stage: RTL and testbench

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

---
 rtl/instr_decode_stage_pkg.sv | 113 +++++++++++
 rtl/instr_decode_stage_field_classify.sv | 32 +++
 rtl/instr_decode_stage.sv | 117 +++++++++++
 tb/tb_instr_decode_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_decode_stage_pkg.sv
// Shared MIPS opcode/funct constants, format-class encodings and decode helpers
// for the instruction decode stage.
package instr_decode_stage_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ADDR_W  = 26;
    localparam int unsigned IMM_W   = 16;

    // Primary opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_BLEZ  = 6'h06;
    localparam logic [OP_W-1:0] OP_BGTZ  = 6'h07;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LB    = 6'h20;
    localparam logic [OP_W-1:0] OP_LH    = 6'h21;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_LBU   = 6'h24;
    localparam logic [OP_W-1:0] OP_LHU   = 6'h25;
    localparam logic [OP_W-1:0] OP_SB    = 6'h28;
    localparam logic [OP_W-1:0] OP_SH    = 6'h29;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [FUNCT_W-1:0] FN_SLL   = 6'h00;
    localparam logic [FUNCT_W-1:0] FN_SRL   = 6'h02;
    localparam logic [FUNCT_W-1:0] FN_SRA   = 6'h03;
    localparam logic [FUNCT_W-1:0] FN_SLLV  = 6'h04;
    localparam logic [FUNCT_W-1:0] FN_SRLV  = 6'h06;
    localparam logic [FUNCT_W-1:0] FN_SRAV  = 6'h07;
    localparam logic [FUNCT_W-1:0] FN_JR    = 6'h08;
    localparam logic [FUNCT_W-1:0] FN_JALR  = 6'h09;
    localparam logic [FUNCT_W-1:0] FN_MFHI  = 6'h10;
    localparam logic [FUNCT_W-1:0] FN_MTHI  = 6'h11;
    localparam logic [FUNCT_W-1:0] FN_MFLO  = 6'h12;
    localparam logic [FUNCT_W-1:0] FN_MTLO  = 6'h13;
    localparam logic [FUNCT_W-1:0] FN_MULT  = 6'h18;
    localparam logic [FUNCT_W-1:0] FN_MULTU = 6'h19;
    localparam logic [FUNCT_W-1:0] FN_DIV   = 6'h1A;
    localparam logic [FUNCT_W-1:0] FN_DIVU  = 6'h1B;
    localparam logic [FUNCT_W-1:0] FN_ADD   = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_ADDU  = 6'h21;
    localparam logic [FUNCT_W-1:0] FN_SUB   = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_SUBU  = 6'h23;
    localparam logic [FUNCT_W-1:0] FN_AND   = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR    = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_XOR   = 6'h26;
    localparam logic [FUNCT_W-1:0] FN_NOR   = 6'h27;
    localparam logic [FUNCT_W-1:0] FN_SLT   = 6'h2A;
    localparam logic [FUNCT_W-1:0] FN_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        ITYPE_R   = 2'd0,
        ITYPE_I   = 2'd1,
        ITYPE_J   = 2'd2,
        ITYPE_ILL = 2'd3
    } itype_e;

    // Decoded fields carried through the buffer (extended immediate kept separately, it is N wide)
    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   shamt;
        logic [FUNCT_W-1:0] funct;
        logic [ADDR_W-1:0]  addr;
        itype_e             itype;
    } dec_fields_t;

    function automatic logic is_r_funct(input logic [FUNCT_W-1:0] f);
        case (f)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JR, FN_JALR,
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
            FN_SLT, FN_SLTU: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic is_i_op(input logic [OP_W-1:0] o);
        case (o)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic is_logic_op(input logic [OP_W-1:0] o);
        return (o == OP_ANDI) || (o == OP_ORI) || (o == OP_XORI);
    endfunction

    function automatic itype_e classify(input logic [OP_W-1:0] o, input logic [FUNCT_W-1:0] f);
        if (o == OP_RTYPE)                return is_r_funct(f) ? ITYPE_R : ITYPE_ILL;
        else if (o == OP_J || o == OP_JAL) return ITYPE_J;
        else if (is_i_op(o))              return ITYPE_I;
        else                              return ITYPE_ILL;
    endfunction

endpackage

// File: rtl/instr_decode_stage_field_classify.sv
// Combinational field extraction, immediate extension and format classification
// of one raw instruction word.
module instr_field_classify
    import instr_decode_stage_pkg::*;
#(
    parameter int unsigned N          = 32,
    parameter bit          ZEXT_LOGIC = 1'b1
) (
    input  logic [N-1:0]  i_instr,
    output dec_fields_t   o_fields,
    output logic [N-1:0]  o_imm_ext
);

    logic w_zext;

    always_comb begin
        o_fields.op    = i_instr[31:26];
        o_fields.rs    = i_instr[25:21];
        o_fields.rt    = i_instr[20:16];
        o_fields.rd    = i_instr[15:11];
        o_fields.shamt = i_instr[10:6];
        o_fields.funct = i_instr[5:0];
        o_fields.addr  = i_instr[25:0];
        o_fields.itype = classify(i_instr[31:26], i_instr[5:0]);
    end

    // Logical immediates are zero-extended only when the build asks for it
    assign w_zext    = ZEXT_LOGIC && is_logic_op(i_instr[31:26]);
    assign o_imm_ext = w_zext ? {{(N-IMM_W){1'b0}},        i_instr[IMM_W-1:0]}
                              : {{(N-IMM_W){i_instr[IMM_W-1]}}, i_instr[IMM_W-1:0]};

endmodule

// File: rtl/instr_decode_stage.sv
// Instruction decode stage: classify incoming words, then buffer decoded results
// in a two-entry (main + skid) register stage with valid/ready handshakes.
module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int unsigned N          = 32,
    parameter bit          ZEXT_LOGIC = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         instr,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OP_W-1:0]      op,
    output logic [REG_W-1:0]     rs,
    output logic [REG_W-1:0]     rt,
    output logic [REG_W-1:0]     rd,
    output logic [REG_W-1:0]     shamt,
    output logic [FUNCT_W-1:0]   funct,
    output logic [N-1:0]         imm_ext,
    output logic [ADDR_W-1:0]    addr,
    output logic [1:0]           itype
);

    dec_fields_t  w_new_fields;
    logic [N-1:0] w_new_imm;

    dec_fields_t  r_main_fields, r_skid_fields;
    logic [N-1:0] r_main_imm, r_skid_imm;
    logic         r_main_valid, r_skid_valid, r_in_ready;

    logic w_accept, w_drain;
    logic w_main_valid_n, w_skid_valid_n;
    logic w_load_main_new, w_load_main_skid, w_load_skid;

    instr_field_classify #(
        .N          (N),
        .ZEXT_LOGIC (ZEXT_LOGIC)
    ) u_classify (
        .i_instr   (instr),
        .o_fields  (w_new_fields),
        .o_imm_ext (w_new_imm)
    );

    assign w_accept = in_valid && r_in_ready;
    assign w_drain  = r_main_valid && out_ready;

    // Next-state of the two entries; skid always feeds main first to keep program order
    always_comb begin
        w_main_valid_n   = r_main_valid;
        w_skid_valid_n   = r_skid_valid;
        w_load_main_new  = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_main_valid_n = 1'b0;
            w_skid_valid_n = 1'b0;
        end else if (!r_main_valid || w_drain) begin
            if (r_skid_valid) begin
                w_main_valid_n   = 1'b1;
                w_load_main_skid = 1'b1;
                w_skid_valid_n   = w_accept;
                w_load_skid      = w_accept;
            end else begin
                w_main_valid_n  = w_accept;
                w_load_main_new = w_accept;
                w_skid_valid_n  = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_valid_n = 1'b1;
            w_load_skid    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid  <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_in_ready    <= 1'b1;
            r_main_fields <= '0;
            r_skid_fields <= '0;
            r_main_imm    <= '0;
            r_skid_imm    <= '0;
        end else begin
            r_main_valid <= w_main_valid_n;
            r_skid_valid <= w_skid_valid_n;
            r_in_ready   <= !w_skid_valid_n;
            if (w_load_main_new) begin
                r_main_fields <= w_new_fields;
                r_main_imm    <= w_new_imm;
            end else if (w_load_main_skid) begin
                r_main_fields <= r_skid_fields;
                r_main_imm    <= r_skid_imm;
            end
            if (w_load_skid) begin
                r_skid_fields <= w_new_fields;
                r_skid_imm    <= w_new_imm;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign op        = r_main_fields.op;
    assign rs        = r_main_fields.rs;
    assign rt        = r_main_fields.rt;
    assign rd        = r_main_fields.rd;
    assign shamt     = r_main_fields.shamt;
    assign funct     = r_main_fields.funct;
    assign addr      = r_main_fields.addr;
    assign itype     = r_main_fields.itype;
    assign imm_ext   = r_main_imm;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode vector table on two builds
// (logical-immediate zero-extend on and off) plus handshake/flush/reset sequences.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic        flush;
    logic        out_ready;

    logic        in_ready,  out_valid;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_ext;
    logic [25:0] addr;
    logic [1:0]  itype;

    logic        s_in_ready, s_out_valid;
    logic [5:0]  s_op, s_funct;
    logic [4:0]  s_rs, s_rt, s_rd, s_shamt;
    logic [31:0] s_imm_ext;
    logic [25:0] s_addr;
    logic [1:0]  s_itype;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_decode_stage #(.N(32), .ZEXT_LOGIC(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm_ext(imm_ext), .addr(addr), .itype(itype)
    );

    instr_decode_stage #(.N(32), .ZEXT_LOGIC(1'b0)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .instr(instr),
        .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
        .op(s_op), .rs(s_rs), .rt(s_rt), .rd(s_rd), .shamt(s_shamt), .funct(s_funct),
        .imm_ext(s_imm_ext), .addr(s_addr), .itype(s_itype)
    );

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [31:0] imm1;
        logic [31:0] imm0;
        logic [25:0] addr;
        logic [1:0]  itype;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input int i, input vec_t v);
        string p;
        p = $sformatf("vec%0d", i);
        check({p, ".out_valid"}, 32'(out_valid), 32'd1);
        check({p, ".op"},    32'(op),    32'(v.op));
        check({p, ".rs"},    32'(rs),    32'(v.rs));
        check({p, ".rt"},    32'(rt),    32'(v.rt));
        check({p, ".rd"},    32'(rd),    32'(v.rd));
        check({p, ".shamt"}, 32'(shamt), 32'(v.shamt));
        check({p, ".funct"}, 32'(funct), 32'(v.funct));
        check({p, ".imm_z"}, imm_ext,    v.imm1);
        check({p, ".addr"},  32'(addr),  32'(v.addr));
        check({p, ".itype"}, 32'(itype), 32'(v.itype));
        check({p, ".s_out_valid"}, 32'(s_out_valid), 32'd1);
        check({p, ".s_op"},    32'(s_op),    32'(v.op));
        check({p, ".s_rs"},    32'(s_rs),    32'(v.rs));
        check({p, ".s_rt"},    32'(s_rt),    32'(v.rt));
        check({p, ".s_rd"},    32'(s_rd),    32'(v.rd));
        check({p, ".s_shamt"}, 32'(s_shamt), 32'(v.shamt));
        check({p, ".s_funct"}, 32'(s_funct), 32'(v.funct));
        check({p, ".imm_s"},   s_imm_ext,    v.imm0);
        check({p, ".s_addr"},  32'(s_addr),  32'(v.addr));
        check({p, ".s_itype"}, 32'(s_itype), 32'(v.itype));
        check({p, ".s_in_ready"}, 32'(s_in_ready), 32'd1);
    endtask

    // Offer one word with out_ready=0; returns after the accepting edge, at negedge
    task automatic push(input logic [31:0] w);
        in_valid = 1'b1;
        instr    = w;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            instr         op     rs  rt  rd  sh  funct  imm(zext=1)   imm(zext=0)   addr          itype
        vecs[0] = '{32'h00221820, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 32'h00001820, 32'h00001820, 26'h0221820, 2'd0};
        vecs[1] = '{32'h2008FFFF, 6'h08, 5'd0, 5'd8, 5'd31, 5'd31, 6'h3F, 32'hFFFFFFFF, 32'hFFFFFFFF, 26'h008FFFF, 2'd1};
        vecs[2] = '{32'h3408FFFF, 6'h0D, 5'd0, 5'd8, 5'd31, 5'd31, 6'h3F, 32'h0000FFFF, 32'hFFFFFFFF, 26'h008FFFF, 2'd1};
        vecs[3] = '{32'h08000010, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h10, 32'h00000010, 32'h00000010, 26'h0000010, 2'd2};
        vecs[4] = '{32'hFC000000, 6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h00000000, 32'h00000000, 26'h0000000, 2'd3};
        vecs[5] = '{32'h0000003F, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h3F, 32'h0000003F, 32'h0000003F, 26'h000003F, 2'd3};
        vecs[6] = '{32'h8C220004, 6'h23, 5'd1, 5'd2, 5'd0, 5'd0, 6'h04, 32'h00000004, 32'h00000004, 26'h0220004, 2'd1};
        vecs[7] = '{32'h0C000100, 6'h03, 5'd0, 5'd0, 5'd0, 5'd4, 6'h00, 32'h00000100, 32'h00000100, 26'h0000100, 2'd2};
        vecs[8] = '{32'h30228000, 6'h0C, 5'd1, 5'd2, 5'd16, 5'd0, 6'h00, 32'h00008000, 32'hFFFF8000, 26'h0228000, 2'd1};
        vecs[9] = '{32'h000A1100, 6'h00, 5'd0, 5'd10, 5'd2, 5'd4, 6'h00, 32'h00001100, 32'h00001100, 26'h00A1100, 2'd0};

        rst = 1'b1; in_valid = 1'b0; instr = 32'h0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready",  32'(in_ready),  32'd1);
        check("rst.op",        32'(op),        32'd0);
        check("rst.rd",        32'(rd),        32'd0);
        check("rst.imm_ext",   imm_ext,        32'd0);
        check("rst.addr",      32'(addr),      32'd0);
        check("rst.itype",     32'(itype),     32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Latency-1 decode with the downstream always ready
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            instr    = vecs[i].instr;
            @(negedge clk);
            in_valid = 1'b0;
            check_all(i, vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d.drained", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: A shown and held, B into skid, C refused until space frees
        out_ready = 1'b0;
        push(32'h00221820);
        check("bp.A.op",   32'(op),   32'h00);
        check("bp.A.addr", 32'(addr), 32'h0221820);
        check("bp.ready1", 32'(in_ready), 32'd1);
        push(32'h8C220004);
        check("bp.ready_drop", 32'(in_ready), 32'd0);
        check("bp.A.hold1",    32'(addr), 32'h0221820);
        push(32'h08000010);
        check("bp.A.hold2",    32'(addr), 32'h0221820);
        check("bp.A.valid",    32'(out_valid), 32'd1);
        check("bp.ready_low",  32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp.B.op",   32'(op),   32'h23);
        check("bp.B.addr", 32'(addr), 32'h0220004);
        check("bp.B.valid", 32'(out_valid), 32'd1);
        check("bp.ready_back", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp.C.op",   32'(op),   32'h02);
        check("bp.C.addr", 32'(addr), 32'h0000010);
        check("bp.C.valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("bp.empty", 32'(out_valid), 32'd0);

        // Flush with both entries full and a word offered
        out_ready = 1'b0;
        push(32'h8C220004);
        push(32'h08000010);
        check("fl.full", 32'(in_ready), 32'd0);
        in_valid = 1'b1; instr = 32'h0C000100; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("fl.out_valid", 32'(out_valid), 32'd0);
        check("fl.in_ready",  32'(in_ready),  32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("fl.quiet%0d", k), 32'(out_valid), 32'd0);
        end

        // Flush ignores a same-cycle accept while in_ready is high
        out_ready = 1'b0;
        push(32'h8C220004);
        in_valid = 1'b1; instr = 32'h0C000100; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("fl2.out_valid", 32'(out_valid), 32'd0);
        check("fl2.in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        check("fl2.quiet", 32'(out_valid), 32'd0);

        // Asynchronous reset between edges with both entries full
        out_ready = 1'b0;
        push(32'h8C220004);
        push(32'h08000010);
        in_valid = 1'b0;
        check("ar.pre_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("ar.out_valid", 32'(out_valid), 32'd0);
        check("ar.in_ready",  32'(in_ready),  32'd1);
        check("ar.op",        32'(op),        32'd0);
        check("ar.rt",        32'(rt),        32'd0);
        check("ar.imm_ext",   imm_ext,        32'd0);
        check("ar.addr",      32'(addr),      32'd0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("ar.quiet%0d", k), 32'(out_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
